// File: rtl/pmodjstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI transaction sequencer.
package pmodjstk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    BYTE_GAP = 3'd3,
    SS_HOLD  = 3'd4,
    FIN      = 3'd5
  } state_t;

  localparam int unsigned NUM_BYTES  = 5;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DATA_W     = NUM_BYTES * BYTE_W;
  localparam int unsigned BYTE_IDX_W = 3;
  localparam int unsigned LED_W      = 2;

  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  // Byte 0 carries the LED command; the remaining bytes are padding.
  function automatic logic [BYTE_W-1:0] tx_byte_sel(input logic [BYTE_IDX_W-1:0] idx,
                                                    input logic [LED_W-1:0]      led);
    return (idx == '0) ? {CMD_PREFIX, led} : '0;
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_mode0_byte_shifter.sv
// SPI mode-0 single-byte engine: SCLK generation, MSB-first MOSI, MISO capture on SCLK rise.
module spi_mode0_byte_shifter
  import pmodjstk_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 750
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_go,
  input  logic              i_prime,
  input  logic [BYTE_W-1:0] i_tx_byte,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_busy,
  output logic              o_done_c,
  output logic [BYTE_W-1:0] o_rx_byte
);

  localparam int unsigned PH_W  = $clog2(SCLK_HALF) + 1;
  localparam int unsigned BIT_W = 3;

  logic              r_active;
  logic [PH_W-1:0]   r_ph;
  logic [BIT_W-1:0]  r_bit;
  logic              r_sclk;
  logic              r_mosi;
  logic [BYTE_W-2:0] r_tx_sr;
  logic [BYTE_W-1:0] r_rx_sr;
  logic              w_ph_end;

  assign w_ph_end  = r_active && (r_ph == PH_W'(SCLK_HALF - 1));
  assign o_done_c  = w_ph_end && r_sclk && (r_bit == BIT_W'(BYTE_W - 1));
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;
  assign o_busy    = r_active;
  assign o_rx_byte = r_rx_sr;

  // Half-period phase counter, bit counter and SCLK toggling.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_active <= 1'b0;
      r_ph     <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
    end else if (!r_active) begin
      r_sclk <= 1'b0;
      if (i_go) begin
        r_active <= 1'b1;
        r_ph     <= '0;
        r_bit    <= '0;
      end
    end else if (w_ph_end) begin
      r_ph   <= '0;
      r_sclk <= ~r_sclk;
      if (r_sclk) begin
        if (r_bit == BIT_W'(BYTE_W - 1)) begin
          r_active <= 1'b0;
        end else begin
          r_bit <= r_bit + BIT_W'(1);
        end
      end
    end else begin
      r_ph <= r_ph + PH_W'(1);
    end
  end

  // MISO captured on the rising edge; MOSI advanced on the falling edge, parked low between bytes
  // except when the sequencer primes the next MSB ahead of the first rise.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_sr <= '0;
      r_rx_sr <= '0;
      r_mosi  <= 1'b0;
    end else if (!r_active) begin
      if (i_go) begin
        r_tx_sr <= i_tx_byte[BYTE_W-2:0];
        r_rx_sr <= '0;
        r_mosi  <= i_tx_byte[BYTE_W-1];
      end else begin
        r_mosi <= i_prime ? i_tx_byte[BYTE_W-1] : 1'b0;
      end
    end else if (w_ph_end) begin
      if (!r_sclk) begin
        r_rx_sr <= {r_rx_sr[BYTE_W-2:0], i_miso};
      end else if (r_bit == BIT_W'(BYTE_W - 1)) begin
        r_mosi <= i_prime ? i_tx_byte[BYTE_W-1] : 1'b0;
      end else begin
        r_mosi  <= r_tx_sr[BYTE_W-2];
        r_tx_sr <= {r_tx_sr[BYTE_W-3:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/pmodjstk_spi_sequencer.sv
// Sequences one 5-byte PmodJSTK SPI exchange: SS framing, inter-byte gaps and response assembly.
module pmodjstk_spi_sequencer
  import pmodjstk_pkg::*;
#(
  parameter int unsigned SCLK_HALF    = 750,
  parameter int unsigned SS_SETUP_CYC = 1500,
  parameter int unsigned BYTE_GAP_CYC = 1000,
  parameter int unsigned SS_HOLD_CYC  = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  LED_CMD,
  input  logic        MISO,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        BUSY,
  output logic        DONE,
  output logic [39:0] DATA_OUT
);

  localparam int unsigned MAX_CYC = max_of(max_of(SCLK_HALF, SS_SETUP_CYC),
                                           max_of(BYTE_GAP_CYC, SS_HOLD_CYC));
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [BYTE_IDX_W-1:0] r_byte;
  logic [BYTE_IDX_W-1:0] w_byte_nxt;
  logic [LED_W-1:0]      r_led;
  logic [LED_W-1:0]      w_led_sel;
  logic [DATA_W-1:0]     r_rx;
  logic [DATA_W-1:0]     r_data_out;
  logic                  r_ss;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_start_shift;
  logic                  w_go;
  logic                  w_prime;
  logic                  w_ss_low_nxt;
  logic                  w_shift_busy;
  logic                  w_shift_done;
  logic [BYTE_W-1:0]     w_tx_byte;
  logic [BYTE_W-1:0]     w_rx_byte;

  // Byte engine; owns SCLK and MOSI.
  spi_mode0_byte_shifter #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .i_go      (w_go),
    .i_prime   (w_prime),
    .i_tx_byte (w_tx_byte),
    .i_miso    (MISO),
    .o_sclk    (SCLK),
    .o_mosi    (MOSI),
    .o_busy    (w_shift_busy),
    .o_done_c  (w_shift_done),
    .o_rx_byte (w_rx_byte)
  );

  // Next-state, counter and shifter-control logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_byte_nxt    = r_byte;
    w_start_shift = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (START) begin
          w_state_nxt = SS_SETUP;
          w_byte_nxt  = '0;
        end
      end
      SS_SETUP: begin
        if (r_cnt == CNT_W'(SS_SETUP_CYC - 1)) begin
          w_state_nxt   = SHIFT;
          w_cnt_nxt     = '0;
          w_start_shift = 1'b1;
        end
      end
      SHIFT: begin
        w_cnt_nxt = '0;
        if (w_shift_done) begin
          if (r_byte < BYTE_IDX_W'(NUM_BYTES - 1)) begin
            w_state_nxt = BYTE_GAP;
            w_byte_nxt  = r_byte + BYTE_IDX_W'(1);
          end else begin
            w_state_nxt = SS_HOLD;
          end
        end
      end
      BYTE_GAP: begin
        if (r_cnt == CNT_W'(BYTE_GAP_CYC - 1)) begin
          w_state_nxt   = SHIFT;
          w_cnt_nxt     = '0;
          w_start_shift = 1'b1;
        end
      end
      SS_HOLD: begin
        if (r_cnt == CNT_W'(SS_HOLD_CYC - 1)) begin
          w_state_nxt = FIN;
          w_cnt_nxt   = '0;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_go         = w_start_shift && !w_shift_busy;
    w_led_sel    = (r_state == IDLE) ? LED_CMD : r_led;
    w_tx_byte    = tx_byte_sel(w_byte_nxt, w_led_sel);
    w_prime      = ((w_state_nxt == SS_SETUP) && (w_cnt_nxt == CNT_W'(SS_SETUP_CYC - 1))) ||
                   ((w_state_nxt == BYTE_GAP) && (w_cnt_nxt == CNT_W'(BYTE_GAP_CYC - 1)));
    w_ss_low_nxt = (w_state_nxt inside {SS_SETUP, SHIFT, BYTE_GAP, SS_HOLD});
  end

  // State, cycle counter and byte counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_byte  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_byte  <= w_byte_nxt;
    end
  end

  // LED command latch and response assembly, first byte ends up in the top bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_led <= '0;
      r_rx  <= '0;
    end else if ((r_state == IDLE) && START) begin
      r_led <= LED_CMD;
      r_rx  <= '0;
    end else if ((r_state == SHIFT) && w_shift_done) begin
      r_rx <= {r_rx[DATA_W-BYTE_W-1:0], w_rx_byte};
    end
  end

  // Registered SS, BUSY, DONE and DATA_OUT, aligned with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ss       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_ss   <= !w_ss_low_nxt;
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == FIN);
      if (w_state_nxt == FIN) begin
        r_data_out <= r_rx;
      end
    end
  end

  assign SS       = r_ss;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign DATA_OUT = r_data_out;

endmodule
